i2c_bus_arbiter: RTL

Shares one I2C_MASTER between NREQ requesters, e.g. the BMP180 sequencer plus a second sensor sequencer. Each requester raises a request and waits for its grant. While granted it owns the master's start/datasend handshake, and it may hold the bus across several transactions (for example a register-pointer write followed by a read). Grants are issued round-robin, and only one requester reaches the master at a time.

---
 rtl/i2c_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C master between NREQ requesters.
// Optional grant watchdog is built when I2C_ARB_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no owner; arbitrate among pending requests when master ready
// ST_GRANT   | owner drives the master's start/datasend handshake
// ST_RELEASE | one-cycle gap with no grant before the next arbitration
module i2c_bus_arbiter #(
    parameter int          NREQ    = 2,
    parameter int          OWNER_W = 1,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     start,
    input  logic [8*NREQ-1:0]   datasend,
    output logic [NREQ-1:0]     gnt,
    output logic [OWNER_W-1:0]  owner,
    output logic                busy,
    output logic [NREQ-1:0]     sended,
    output logic [NREQ-1:0]     received,
    output logic [7:0]          datareceive,
    output logic                timeout,
    input  logic                m_ready,
    input  logic                m_sended,
    input  logic                m_received,
    input  logic [7:0]          m_datareceive,
    output logic                m_start,
    output logic [7:0]          m_datasend
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

    state_t               state, state_nxt;
    logic [OWNER_W-1:0]   owner_nxt, sel;
    logic                 sel_found;
    logic [NREQ-1:0]      owner_1h;
    logic                 own_start;
    logic [7:0]           own_data;
    logic                 granted;
    logic                 wd_hit;

    // Search starts just past the last owner so priority rotates.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!sel_found && req[j] && (j == (int'(owner) + i) % NREQ)) begin
                    sel       = OWNER_W'(j);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_1h  = '0;
        own_start = 1'b0;
        own_data  = 8'h00;
        for (int j = 0; j < NREQ; j++) begin
            if (OWNER_W'(j) == owner) begin
                owner_1h[j] = 1'b1;
                own_start   = start[j];
                own_data    = datasend[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ST_IDLE: begin
                if (sel_found && m_ready) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = sel;
                end
            end
            ST_GRANT: begin
                // A dropped request waits for m_ready so a transaction is never cut.
                if (wd_hit || (((req & owner_1h) == '0) && m_ready))
                    state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            owner <= OWNER_W'(NREQ - 1);
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    assign granted     = (state == ST_GRANT);
    assign gnt         = granted ? owner_1h : '0;
    assign busy        = (state != ST_IDLE);
    assign m_start     = granted && own_start && !wd_hit;
    assign m_datasend  = granted ? own_data : 8'h00;
    assign sended      = (granted && m_sended) ? owner_1h : '0;
    assign received    = (granted && m_received) ? owner_1h : '0;
    assign datareceive = m_datareceive;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        timeout_q;

    assign wd_hit  = granted && (wd_cnt == TIMEOUT - 16'd1);
    assign timeout = timeout_q;

    // Any handshake activity from the owner or master proves the bus is alive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_hit;
            if (!granted || own_start || m_sended || m_received)
                wd_cnt <= '0;
            else if (!wd_hit)
                wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
